// File: rtl/softmax_engine_if.sv
// Handshake and data bundle between the classifier head and the softmax engine.
// The producer/consumer side uses master; the engine uses slave.
interface softmax_engine_if #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int PROB_W    = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic [N_CLASSES*DATA_W-1:0]    logits;
    logic                           out_valid;
    logic                           out_ready;
    logic [N_CLASSES*PROB_W-1:0]    probs;
    logic [$clog2(N_CLASSES)-1:0]   argmax;
    logic [DATA_W-1:0]              max_logit;

    modport master (
        output in_valid, logits, out_ready,
        input  in_ready, out_valid, probs, argmax, max_logit
    );

    modport slave (
        input  in_valid, logits, out_ready,
        output in_ready, out_valid, probs, argmax, max_logit
    );
endinterface

// File: rtl/softmax_engine.sv
// Sequential softmax: max search, base-2 shift exponent, accumulate, then one
// restoring division per class. Also reports argmax and the max logit.
module softmax_engine #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int FRAC      = 12,
    parameter int PROB_W    = 16,
    parameter int LOG2E_Q   = 5909
) (
    input  logic             clk,
    input  logic             rst,
    softmax_engine_if.slave  bus
);
    localparam int IDX_W  = $clog2(N_CLASSES);
    localparam int E_W    = FRAC + 1;
    localparam int SUM_W  = FRAC + 1 + $clog2(N_CLASSES);
    localparam int REM_W  = SUM_W + 1;
    localparam int STEP_W = $clog2(PROB_W + 1);
    localparam int LQ_W   = $clog2(LOG2E_Q + 1);
    localparam int PROD_W = DATA_W + 1 + LQ_W;

    localparam logic [IDX_W-1:0]  LAST     = IDX_W'(N_CLASSES - 1);
    localparam logic [E_W-1:0]    ONE      = {1'b1, {FRAC{1'b0}}};
    localparam logic [LQ_W-1:0]   LOG2E_C  = LQ_W'(LOG2E_Q);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PROB_W);

    typedef enum logic [2:0] {
        S_IDLE, S_MAX, S_EXP, S_SUM, S_DIV, S_DONE
    } state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [IDX_W-1:0]          count_q;
    logic [IDX_W-1:0]          argmax_q;
    logic [STEP_W-1:0]         step_q;
    logic signed [DATA_W-1:0]  x_q [N_CLASSES];
    logic signed [DATA_W-1:0]  max_q;
    logic [E_W-1:0]            e_q [N_CLASSES];
    logic [SUM_W-1:0]          sum_q;
    logic [REM_W-1:0]          rem_q;
    logic [PROB_W-2:0]         quo_q;
    logic [PROB_W-1:0]         probs_q [N_CLASSES];

    logic signed [DATA_W-1:0]  x_cur;
    logic signed [DATA_W:0]    diff;
    logic [DATA_W:0]           neg_diff;
    logic [PROD_W-1:0]         prod;
    logic [PROD_W-1:0]         m_val;
    logic [PROD_W-1:0]         k_val;
    logic [FRAC-1:0]           g_val;
    logic [E_W-1:0]            e_base;
    logic [E_W-1:0]            e_d;
    logic [E_W-1:0]            e_sel;
    logic                      rem_ge;
    logic [REM_W-1:0]          rem_d;
    logic [PROB_W-1:0]         quo_d;

    // 2^(-m) with m in Q.FRAC: integer part is a shift, fraction uses 1 - g/2.
    always_comb begin
        x_cur    = x_q[count_q];
        diff     = {x_cur[DATA_W-1], x_cur} - {max_q[DATA_W-1], max_q};
        neg_diff = -diff;
        prod     = PROD_W'(neg_diff) * PROD_W'(LOG2E_C);
        m_val    = prod >> FRAC;
        k_val    = m_val >> FRAC;
        g_val    = m_val[FRAC-1:0];
        e_base   = ONE - E_W'(g_val >> 1);
        e_d      = (k_val > PROD_W'(FRAC)) ? '0 : (e_base >> k_val);
        e_sel    = e_q[count_q];
        rem_ge   = rem_q >= REM_W'(sum_q);
        rem_d    = (rem_ge ? (rem_q - REM_W'(sum_q)) : rem_q) << 1;
        quo_d    = {quo_q, rem_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            argmax_q    <= '0;
            step_q      <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            for (int unsigned i = 0; i < N_CLASSES; i++) probs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        for (int unsigned i = 0; i < N_CLASSES; i++)
                            x_q[i] <= bus.logits[i*DATA_W +: DATA_W];
                        count_q    <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MAX;
                    end
                end
                S_MAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if (count_q == '0 || x_cur > max_q) begin
                        max_q    <= x_cur;
                        argmax_q <= count_q;
                    end
                    if (count_q == LAST) begin
                        count_q <= '0;
                        state_q <= S_EXP;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_EXP: begin
                    e_q[count_q] <= e_d;
                    if (count_q == LAST) begin
                        count_q <= '0;
                        state_q <= S_SUM;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_SUM: begin
                    sum_q <= sum_q + SUM_W'(e_sel);
                    if (count_q == LAST) begin
                        count_q <= '0;
                        step_q  <= '0;
                        state_q <= S_DIV;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_DIV: begin
                    // Step 0 loads the numerator; steps 1..PROB_W each emit one quotient bit.
                    if (step_q == '0) begin
                        rem_q  <= REM_W'(e_sel);
                        quo_q  <= '0;
                        step_q <= step_q + 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d[PROB_W-2:0];
                        if (step_q == LAST_STEP) begin
                            probs_q[count_q] <= quo_d;
                            step_q           <= '0;
                            if (count_q == LAST) begin
                                count_q     <= '0;
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                count_q <= count_q + 1'b1;
                            end
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.probs = '0;
        for (int unsigned i = 0; i < N_CLASSES; i++)
            bus.probs[i*PROB_W +: PROB_W] = probs_q[i];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.argmax    = argmax_q;
    assign bus.max_logit = max_q;
endmodule

// File: tb/tb_softmax_engine.sv
// Directed bench for softmax_engine: table of hand-computed vectors plus
// sequences for backpressure, back-to-back acceptance and mid-operation reset.
module tb_softmax_engine;
    localparam int N   = 10;
    localparam int DW  = 16;
    localparam int PW  = 16;
    localparam int VW  = N * DW;
    localparam int LAT = 3 * N + N * (PW + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    softmax_engine_if #(.N_CLASSES(N), .DATA_W(DW), .PROB_W(PW)) bus ();

    softmax_engine #(
        .N_CLASSES(N), .DATA_W(DW), .FRAC(12), .PROB_W(PW), .LOG2E_Q(5909)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [VW-1:0] lg;
        logic [VW-1:0] pr;
        logic [3:0]    am;
        logic [15:0]   mx;
    } vec_t;

    vec_t tbl [6];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input logic [15:0] base, input int ia,
                                         input logic [15:0] va, input int ib,
                                         input logic [15:0] vb);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++)
            r[i*16 +: 16] = (i == ia) ? va : ((i == ib) ? vb : base);
        return r;
    endfunction

    // Presents a vector, waits for acceptance, then scrambles the port.
    task automatic send(input logic [VW-1:0] lg);
        int t;
        t = 0;
        @(negedge clk);
        bus.logits   = lg;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", VW'(bus.in_ready), VW'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.logits   = ~lg;
        chk("busy_in_ready", VW'(bus.in_ready), VW'(0));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 400);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s prob[%0d]", tag, i), VW'(bus.probs[i*16 +: 16]), VW'(v.pr[i*16 +: 16]));
        chk($sformatf("%s argmax", tag), VW'(bus.argmax), VW'(v.am));
        chk($sformatf("%s max_logit", tag), VW'(bus.max_logit), VW'(v.mx));
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consume out_valid", VW'(bus.out_valid), VW'(0));
        chk("consume in_ready", VW'(bus.in_ready), VW'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int            lat;
        logic [VW-1:0] snap;
        bit            seen;

        tbl[0] = '{lg: mk(16'h1000, 0, 16'h1000, 0, 16'h1000), pr: mk(16'd3276, 0, 16'd3276, 0, 16'd3276),
                   am: 4'd0, mx: 16'h1000};
        tbl[1] = '{lg: mk(16'h0000, 3, 16'h2000, 3, 16'h2000), pr: mk(16'd2024, 3, 16'd14547, 3, 16'd14547),
                   am: 4'd3, mx: 16'h2000};
        tbl[2] = '{lg: mk(16'hC000, 0, 16'h4000, 0, 16'h4000), pr: mk(16'd7, 0, 16'd32696, 0, 16'd32696),
                   am: 4'd0, mx: 16'h4000};
        tbl[3] = '{lg: mk(16'hE000, 2, 16'h2000, 7, 16'h2000), pr: mk(16'd289, 2, 16'd15224, 7, 16'd15224),
                   am: 4'd2, mx: 16'h2000};
        tbl[4] = '{lg: mk(16'h8000, 0, 16'h8000, 0, 16'h8000), pr: mk(16'd3276, 0, 16'd3276, 0, 16'd3276),
                   am: 4'd0, mx: 16'h8000};
        tbl[5] = '{lg: mk(16'h8000, 9, 16'h7FFF, 9, 16'h7FFF), pr: mk(16'd0, 9, 16'd32768, 9, 16'd32768),
                   am: 4'd9, mx: 16'h7FFF};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.logits    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", VW'(bus.in_ready), VW'(1));
        chk("reset out_valid", VW'(bus.out_valid), VW'(0));
        chk("reset probs", bus.probs, '0);
        chk("reset argmax", VW'(bus.argmax), VW'(0));
        chk("reset max_logit", VW'(bus.max_logit), VW'(0));
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send(tbl[v].lg);
            wait_done(lat);
            chk($sformatf("vec%0d latency", v), VW'(lat), VW'(LAT));
            check_result(tbl[v], $sformatf("vec%0d", v));
            consume();
        end

        // Backpressure with a competing request, then acceptance right after release.
        send(tbl[1].lg);
        wait_done(lat);
        chk("bp latency", VW'(lat), VW'(LAT));
        snap = bus.probs;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.logits   = tbl[0].lg;
            chk($sformatf("bp%0d out_valid", c), VW'(bus.out_valid), VW'(1));
            chk($sformatf("bp%0d in_ready", c), VW'(bus.in_ready), VW'(0));
            chk($sformatf("bp%0d probs", c), bus.probs, snap);
            chk($sformatf("bp%0d argmax", c), VW'(bus.argmax), VW'(3));
        end
        check_result(tbl[1], "bp_hold");
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release out_valid", VW'(bus.out_valid), VW'(0));
        chk("release in_ready", VW'(bus.in_ready), VW'(1));
        @(posedge clk);
        #1;
        chk("b2b accepted", VW'(bus.in_ready), VW'(0));
        bus.in_valid = 1'b0;
        bus.logits   = ~tbl[0].lg;
        wait_done(lat);
        chk("b2b latency", VW'(lat), VW'(LAT));
        check_result(tbl[0], "b2b");
        consume();

        // Abort during the division phase.
        send(tbl[1].lg);
        repeat (100) @(posedge clk);
        #1;
        chk("abort pre out_valid", VW'(bus.out_valid), VW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort in_ready", VW'(bus.in_ready), VW'(1));
        chk("abort out_valid", VW'(bus.out_valid), VW'(0));
        chk("abort probs", bus.probs, '0);
        chk("abort argmax", VW'(bus.argmax), VW'(0));
        chk("abort max_logit", VW'(bus.max_logit), VW'(0));
        seen = 1'b0;
        repeat (250) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort no out_valid", VW'(seen), VW'(0));
        send(tbl[2].lg);
        wait_done(lat);
        chk("post_abort latency", VW'(lat), VW'(LAT));
        check_result(tbl[2], "post_abort");
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
